piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parametrised parallel-in/serial-out serializer, next generation of the 4-bit PISO.
//   Accepts WIDTH-bit words over a valid/ready load handshake and shifts them out one bit per enabled cycle.
//   Bit order (MSB- or LSB-first) is selected per word.
//   Supports stall (shift_en) and gap-free back-to-back words, with frame markers for the downstream serial sink.
// PARAMETERS
//   WIDTH       8   data word width in bits, >= 2
//   IDLE_LEVEL  0   serial_out level when no word is being shifted (0 or 1)
// PORTS
//   clk          input   1              rising-edge clock
//   rst          input   1              asynchronous, active-high reset
//   load_valid   input   1              parallel_in/lsb_first are valid
//   load_ready   output  1              serializer can accept a word this cycle
//   parallel_in  input   WIDTH          word to serialize
//   lsb_first    input   1              1 = LSB first, 0 = MSB first; captured with the word
//   shift_en     input   1              1 = advance one bit this cycle, 0 = hold
//   serial_out   output  1              current serial bit
//   serial_valid output  1              serial_out carries a data bit
//   first_bit    output  1              serial_out is bit 0 of a word in transmit order
//   last_bit     output  1              serial_out is the final bit of a word
//   busy         output  1              word in progress (state SHIFT)
// BEHAVIOUR
// - Reset (async, immediate), all registered outputs:
//   - state=IDLE; shift register=0; bit count=0.
//   - serial_out=IDLE_LEVEL; serial_valid=0; first_bit=0; last_bit=0; busy=0.
// - FSM states IDLE and SHIFT.
//   - IDLE -> SHIFT when load_valid && load_ready.
//   - SHIFT -> IDLE after the last bit shifts out with no new word accepted.
//   - SHIFT -> SHIFT when a new word is accepted on the last-bit cycle.
// - load_ready (combinational) = IDLE || (SHIFT && count==WIDTH-1 && shift_en).
//   - load_ready is 1 in IDLE even while rst is high; no word is captured while rst is high.
//   - load_valid with load_ready=0 is ignored; the word in flight is unaffected.
// - Accept: parallel_in and lsb_first are registered on the accepting edge, and count is set to 0.
//   - Latency 1: the next cycle shows the first bit with serial_valid=1 and first_bit=1.
//   - Loading from IDLE does not require shift_en.
// - Shifting: each cycle with shift_en=1 in SHIFT presents the next bit and increments count.
//   - MSB-first order is bit WIDTH-1 down to bit 0; LSB-first order is bit 0 up to bit WIDTH-1.
//   - shift_en=0 holds serial_out, count, first_bit and last_bit; serial_valid stays 1.
//   - last_bit=1 while count==WIDTH-1.
// - Word end: on the last-bit cycle with shift_en=1:
//   - With a word accepted, the new word's first bit follows with no gap.
//   - Otherwise: IDLE, serial_out=IDLE_LEVEL, serial_valid=0.
// - Bit count is $clog2(WIDTH) bits wide. It never exceeds WIDTH-1, so no wrap-around occurs.
// - Reset mid-word discards the word. The next accepted word starts at its first bit.
// STRUCTURE
//   Shared package shift_pkg:
//     - state enum piso_state_t {IDLE, SHIFT}
//     - localparam function for count width: clog2 of WIDTH
//   Sub-module piso_bit_counter:
//     - Ports: clear, enable, count; terminal flag at WIDTH-1.
//     - Asynchronous, active-high rst.
//   Shift register, order mux and FSM stay in this module.
// TESTING (WIDTH=8, IDLE_LEVEL=0)
//   1. Load 8'hB4, lsb_first=0, shift_en=1
//      -> serial_out 1,0,1,1,0,1,0,0 on cycles 1..8 after accept.
//      -> first_bit on cycle 1 and last_bit on cycle 8; serial_valid=0 and serial_out=0 on cycle 9.
//   2. Load 8'hB4, lsb_first=1 -> serial_out 0,0,1,0,1,1,0,1.
//   3. 8'hA5 then 8'h3C (MSB first), load_valid held, shift_en=1
//      -> 16 contiguous valid bits 10100101 00111100.
//      -> load_ready high only in IDLE and on the last-bit cycle.
//   4. 8'hB4 MSB-first; shift_en=0 for 3 cycles after bit 3 shows
//      -> serial_out holds 1, serial_valid=1, last_bit=0.
//      -> Remaining bits 0,1,0,0 follow when shift_en returns to 1.
//   5. rst pulse after bit 4 of 8'hFF
//      -> Same cycle: serial_valid=0, serial_out=0, busy=0.
//      -> Load 8'h81 after release: output is 1,0,0,0,0,0,0,1.
//   6. load_valid with 8'h00 during bit 2 of 8'hF0 -> ignored; 8'hF0 completes unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the PISO serializer family.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit-count width; a 1-bit floor keeps degenerate widths legal.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serialized word; saturates at WIDTH-1.
module piso_bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !terminal) count <= count + 1'b1;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-word bit order,
// stall support and gap-free back-to-back words.
module piso_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IDLE_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int   CW       = cnt_width(WIDTH);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

  piso_state_t      state, state_next;
  logic [WIDTH-1:0] shreg;
  logic             lsb_r;
  logic             sout_r;
  logic             first_r;
  logic [CW-1:0]    count;
  logic             term;
  logic             accept;
  logic             advance;

  assign busy         = (state == SHIFT);
  assign serial_valid = busy;
  assign serial_out   = sout_r;
  assign first_bit    = first_r;
  assign last_bit     = busy && term;
  assign advance      = busy && shift_en;
  assign load_ready   = (state == IDLE) || (advance && term);
  assign accept       = load_valid && load_ready;

  // Counter returns to 0 at word end so IDLE always sits at a clean count.
  piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept || (advance && term)),
    .enable   (advance),
    .count    (count),
    .terminal (term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (advance && term && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // serial_out is registered; shreg holds only the bits not yet presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      lsb_r   <= 1'b0;
      sout_r  <= IDLE_BIT;
      first_r <= 1'b0;
    end else if (accept) begin
      lsb_r   <= lsb_first;
      first_r <= 1'b1;
      if (lsb_first) begin
        sout_r <= parallel_in[0];
        shreg  <= parallel_in >> 1;
      end else begin
        sout_r <= parallel_in[WIDTH-1];
        shreg  <= parallel_in << 1;
      end
    end else if (advance) begin
      first_r <= 1'b0;
      if (term) begin
        sout_r <= IDLE_BIT;
      end else if (lsb_r) begin
        sout_r <= shreg[0];
        shreg  <= shreg >> 1;
      end else begin
        sout_r <= shreg[WIDTH-1];
        shreg  <= shreg << 1;
      end
    end
  end

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=8, IDLE_LEVEL=0).
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] parallel_in = '0;
  logic         lsb_first = 1'b0;
  logic         shift_en = 1'b1;
  logic         serial_out, serial_valid, first_bit, last_bit, busy;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .parallel_in  (parallel_in),
    .lsb_first    (lsb_first),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .first_bit    (first_bit),
    .last_bit     (last_bit),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare displayed bit with scoreboard head, pop on advance,
  // push a new word's bits when the handshake completes.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (rst) begin
      q.delete();
      chk("rst_valid", serial_valid, 0);
      chk("rst_out", serial_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_first", first_bit, 0);
      chk("rst_last", last_bit, 0);
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && shift_en);
      chk("load_ready", load_ready, exp_rdy);
      if (q.size() > 0) begin
        e = q[0];
        chk("valid", serial_valid, 1);
        chk("busy", busy, 1);
        chk("bit", serial_out, e.b);
        chk("first", first_bit, e.f);
        chk("last", last_bit, e.l);
        if (shift_en) void'(q.pop_front());
      end else begin
        chk("idle_valid", serial_valid, 0);
        chk("idle_out", serial_out, 0);
        chk("idle_busy", busy, 0);
        chk("idle_last", last_bit, 0);
      end
      if (load_valid && exp_rdy) begin
        for (int i = 0; i < W; i++) begin
          e.b = lsb_first ? parallel_in[i] : parallel_in[W-1-i];
          e.f = (i == 0);
          e.l = (i == W - 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic lsb);
    int n;
    load_valid  = 1'b1;
    parallel_in = w;
    lsb_first   = lsb;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready && n < 200);
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || serial_valid) && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
    step(2);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // MSB-first and LSB-first single words
    send(8'hB4, 1'b0);
    wait_idle();
    send(8'hB4, 1'b1);
    wait_idle();

    // back-to-back with load_valid held across the boundary
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b0);
    wait_idle();

    // stall for 3 cycles while the third bit is displayed
    send(8'hB4, 1'b0);
    step(2);
    shift_en = 1'b0;
    step(3);
    shift_en = 1'b1;
    wait_idle();

    // reset mid-word, then a fresh word
    send(8'hFF, 1'b0);
    step(3);
    rst = 1'b1;
    #1;
    chk("async_valid", serial_valid, 0);
    chk("async_out", serial_out, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", load_ready, 1);
    step(2);
    rst = 1'b0;
    step(1);
    send(8'h81, 1'b0);
    wait_idle();

    // load attempt mid-word must be ignored
    send(8'hF0, 1'b0);
    step(1);
    load_valid  = 1'b1;
    parallel_in = 8'h00;
    step(2);
    load_valid = 1'b0;
    wait_idle();

    // random mix with random stalls
    for (int k = 0; k < 6; k++) begin
      send(W'($urandom), 1'($urandom));
      repeat (10) begin
        shift_en = 1'($urandom_range(0, 3) != 0);
        step(1);
      end
      shift_en = 1'b1;
    end
    wait_idle();

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
